// File: rtl/ooo_types_pkg.sv
// Shared types for the out-of-order issue/scoreboard slice.
// Register index, ROB tag, writeback clear bundle and helpers.
package ooo_types_pkg;

  localparam int REG_IDX_W    = 5;
  localparam int ROB_TAG_W    = 4;
  localparam int NUM_WB_PORTS = 4;

  typedef logic [REG_IDX_W-1:0] regidx_t;
  typedef logic [ROB_TAG_W-1:0] rob_tag_t;

  typedef struct packed {
    logic     valid;
    regidx_t  rd;
    rob_tag_t tag;
  } wb_clear_t;

  typedef enum logic [1:0] {
    WB_ARITH,
    WB_MUL,
    WB_DIV,
    WB_LS
  } wb_port_e;

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + 6'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/ooo_sb_entry.sv
// One scoreboard entry: busy bit plus owning ROB tag.
// Ports: set/set_tag from dispatch, clr_req/wb_tag from writeback, flush.
module ooo_sb_entry
  import ooo_types_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          set,
  input  rob_tag_t                      set_tag,
  input  logic     [NUM_WB_PORTS-1:0]   clr_req,
  input  rob_tag_t [NUM_WB_PORTS-1:0]   wb_tag,
  input  logic                          flush,
  output logic                          busy,
  output logic                          busy_nxt,
  output logic                          clr_hit
);

  logic     busy_q, busy_d;
  rob_tag_t tag_q, tag_d;

  always_comb begin
    clr_hit = 1'b0;
    for (int p = 0; p < NUM_WB_PORTS; p++) begin
      if (clr_req[p] && wb_tag[p] == tag_q) clr_hit = 1'b1;
    end
    clr_hit = clr_hit & busy_q;

    busy_d = busy_q;
    tag_d  = tag_q;
    // flush beats dispatch; dispatch beats a same-cycle clear
    if (flush) begin
      busy_d = 1'b0;
    end else if (set) begin
      busy_d = 1'b1;
      tag_d  = set_tag;
    end else if (clr_hit) begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      tag_q  <= '0;
    end else begin
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

  assign busy     = busy_q;
  assign busy_nxt = busy_d;

endmodule

// File: rtl/ooo_reg_scoreboard.sv
// Register busy scoreboard: dispatch sets, tagged writeback clears.
// Ports: rs1/rs2/rd lookup, dispatch, NUM_WB wb ports, flush, counts.
module ooo_reg_scoreboard
  import ooo_types_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int TAG_W    = ROB_TAG_W,
  parameter int NUM_WB   = NUM_WB_PORTS
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic [4:0]              rs1,
  input  logic [4:0]              rs2,
  input  logic [4:0]              rd,
  input  logic                    dispatch_en,
  input  logic [TAG_W-1:0]        dispatch_tag,
  input  logic [NUM_WB-1:0]       wb_valid,
  input  logic [NUM_WB*5-1:0]     wb_rd,
  input  logic [NUM_WB*TAG_W-1:0] wb_tag,
  input  logic                    flush,
  output logic                    rs1_busy,
  output logic                    rs2_busy,
  output logic                    rd_busy,
  output logic [5:0]              busy_count,
  output logic                    all_clear
);

  wb_clear_t [NUM_WB-1:0] wb;
  rob_tag_t  [NUM_WB-1:0] wb_tags;

  always_comb begin
    for (int p = 0; p < NUM_WB; p++) begin
      wb[p].valid = wb_valid[p];
      wb[p].rd    = wb_rd[p*5 +: 5];
      wb[p].tag   = wb_tag[p*TAG_W +: TAG_W];
      wb_tags[p]  = wb[p].tag;
    end
  end

  logic [NUM_REGS-1:0] busy, busy_nxt, hit_v;

  // x0 never tracks a writer
  assign busy[0]     = 1'b0;
  assign busy_nxt[0] = 1'b0;
  assign hit_v[0]    = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_ent
    logic              set;
    logic [NUM_WB-1:0] clr_req;

    assign set = dispatch_en && (rd == 5'(r));

    always_comb begin
      for (int p = 0; p < NUM_WB; p++) begin
        clr_req[p] = wb[p].valid && (wb[p].rd == 5'(r));
      end
    end

    ooo_sb_entry u_ent (
      .clk      (CLK),
      .rst_n    (nRST),
      .set      (set),
      .set_tag  (dispatch_tag),
      .clr_req  (clr_req),
      .wb_tag   (wb_tags),
      .flush    (flush),
      .busy     (busy[r]),
      .busy_nxt (busy_nxt[r]),
      .clr_hit  (hit_v[r])
    );
  end

  logic [5:0] count_q, count_d;

  assign count_d = popcount(busy_nxt);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) count_q <= '0;
    else       count_q <= count_d;
  end

  assign rs1_busy   = busy[rs1];
  assign rs2_busy   = busy[rs2];
  assign rd_busy    = busy[rd];
  assign busy_count = count_q;
  assign all_clear  = (count_q == '0);

  // redispatch is legal only when the old writer retires this same cycle
  a_no_busy_dispatch : assert property (
    @(posedge CLK) disable iff (!nRST)
    !(dispatch_en && !flush && rd != '0 && busy[rd] && !hit_v[rd])
  );

endmodule

// File: tb/tb_ooo_reg_scoreboard.sv
// Bench for ooo_reg_scoreboard: directed plan plus random traffic.
// Reference model keeps per-register busy/owner arrays.
module tb_ooo_reg_scoreboard;
  import ooo_types_pkg::*;

  logic        CLK;
  logic        nRST;
  logic [4:0]  rs1, rs2, rd;
  logic        dispatch_en;
  logic [3:0]  dispatch_tag;
  logic [3:0]  wb_valid;
  logic [19:0] wb_rd;
  logic [15:0] wb_tag;
  logic        flush;
  logic        rs1_busy, rs2_busy, rd_busy;
  logic [5:0]  busy_count;
  logic        all_clear;

  logic [4:0]  wbr [4];
  logic [3:0]  wbt [4];

  always_comb begin
    for (int p = 0; p < 4; p++) begin
      wb_rd[p*5 +: 5]  = wbr[p];
      wb_tag[p*4 +: 4] = wbt[p];
    end
  end

  ooo_reg_scoreboard dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .rs1          (rs1),
    .rs2          (rs2),
    .rd           (rd),
    .dispatch_en  (dispatch_en),
    .dispatch_tag (dispatch_tag),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_tag       (wb_tag),
    .flush        (flush),
    .rs1_busy     (rs1_busy),
    .rs2_busy     (rs2_busy),
    .rd_busy      (rd_busy),
    .busy_count   (busy_count),
    .all_clear    (all_clear)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  bit       m_busy [32];
  bit [3:0] m_own  [32];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic bit m_look(input logic [4:0] idx);
    return (idx != 0) && m_busy[idx];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_busy[i] = 1'b0;
      m_own[i]  = '0;
    end
  endtask

  task automatic m_step();
    bit nb [32];
    nb = m_busy;
    if (flush) begin
      for (int i = 0; i < 32; i++) nb[i] = 1'b0;
    end else begin
      for (int p = 0; p < 4; p++) begin
        if (wb_valid[p] && wbr[p] != 0 && m_busy[wbr[p]] &&
            m_own[wbr[p]] == wbt[p])
          nb[wbr[p]] = 1'b0;
      end
      if (dispatch_en && rd != 0) begin
        nb[rd]    = 1'b1;
        m_own[rd] = dispatch_tag;
      end
    end
    m_busy = nb;
  endtask

  task automatic idle();
    dispatch_en  = 1'b0;
    dispatch_tag = '0;
    rd           = '0;
    flush        = 1'b0;
    wb_valid     = '0;
    for (int p = 0; p < 4; p++) begin
      wbr[p] = '0;
      wbt[p] = '0;
    end
  endtask

  task automatic check_outs(input string tag);
    check({tag, "_rs1"}, 32'(rs1_busy), 32'(m_look(rs1)));
    check({tag, "_rs2"}, 32'(rs2_busy), 32'(m_look(rs2)));
    check({tag, "_rd"}, 32'(rd_busy), 32'(m_look(rd)));
    check({tag, "_cnt"}, 32'(busy_count), 32'(m_count()));
    check({tag, "_clr"}, 32'(all_clear), 32'(m_count() == 0));
  endtask

  // inputs are applied near the negedge; check, clock, update model
  task automatic cycle(input string tag);
    #1;
    check_outs(tag);
    @(posedge CLK);
    if (nRST) m_step();
    else      m_reset();
    @(negedge CLK);
  endtask

  task automatic disp(input logic [4:0] r, input logic [3:0] t);
    dispatch_en  = 1'b1;
    rd           = r;
    dispatch_tag = t;
  endtask

  task automatic wbp(input int p, input logic [4:0] r,
                     input logic [3:0] t);
    wb_valid[p] = 1'b1;
    wbr[p]      = r;
    wbt[p]      = t;
  endtask

  initial begin
    idle();
    rs1  = 5'd5;
    rs2  = 5'd6;
    rd   = 5'd7;
    nRST = 1'b0;
    m_reset();
    repeat (2) @(negedge CLK);
    #1;
    check("t1_rs1", 32'(rs1_busy), 0);
    check("t1_rs2", 32'(rs2_busy), 0);
    check("t1_rd", 32'(rd_busy), 0);
    check("t1_cnt", 32'(busy_count), 0);
    check("t1_clr", 32'(all_clear), 1);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);

    // 2: dispatch then matching writeback
    idle(); disp(5'd5, 4'd3); cycle("t2a");
    idle(); rs1 = 5'd5; #1;
    check("t2_busy", 32'(rs1_busy), 1);
    check("t2_cnt1", 32'(busy_count), 1);
    wbp(int'(WB_ARITH), 5'd5, 4'd3); cycle("t2b");
    idle(); #1;
    check("t2_free", 32'(rs1_busy), 0);
    check("t2_allclr", 32'(all_clear), 1);
    cycle("t2c");

    // 3: x0 dispatch ignored; stale tag ignored
    idle(); disp(5'd0, 4'd2); cycle("t3a");
    idle(); #1;
    check("t3_x0cnt", 32'(busy_count), 0);
    disp(5'd5, 4'd4); cycle("t3b");
    idle(); wbp(1, 5'd5, 4'd9); cycle("t3c");
    idle(); rs1 = 5'd5; #1;
    check("t3_stale", 32'(rs1_busy), 1);
    wbp(2, 5'd5, 4'd4); cycle("t3d");

    // 4: dispatch wins over same-cycle writeback
    idle(); disp(5'd8, 4'd1); cycle("t4a");
    idle(); disp(5'd8, 4'd6); wbp(0, 5'd8, 4'd1); cycle("t4b");
    idle(); rs2 = 5'd8; #1;
    check("t4_keep", 32'(rs2_busy), 1);
    wbp(3, 5'd8, 4'd1); cycle("t4c");
    idle(); wbp(3, 5'd8, 4'd6); cycle("t4d");
    idle(); #1;
    check("t4_gone", 32'(rs2_busy), 0);

    // 5: fill every register, then flush with a dispatch
    for (int r = 1; r < 32; r++) begin
      idle(); disp(5'(r), 4'(r)); cycle("t5fill");
    end
    idle(); #1;
    check("t5_full", 32'(busy_count), 31);
    check("t5_nclr", 32'(all_clear), 0);
    flush = 1'b1; disp(5'd2, 4'd7); cycle("t5f");
    idle(); rs1 = 5'd2; #1;
    check("t5_fcnt", 32'(busy_count), 0);
    check("t5_frs1", 32'(rs1_busy), 0);

    // 6: four ports clear four registers at once
    for (int i = 0; i < 4; i++) begin
      idle(); disp(5'(10 + i), 4'(i)); cycle("t6fill");
    end
    idle();
    for (int p = 0; p < 4; p++) wbp(p, 5'(10 + p), 4'(p));
    cycle("t6wb");
    idle(); #1;
    check("t6_cnt", 32'(busy_count), 0);

    // async reset mid-operation
    disp(5'd20, 4'd5); cycle("t6d");
    idle(); rs1 = 5'd20; disp(5'd21, 4'd6); cycle("t6e");
    idle();
    #3 nRST = 1'b0;
    #1;
    check("rst_rs1", 32'(rs1_busy), 0);
    check("rst_cnt", 32'(busy_count), 0);
    check("rst_clr", 32'(all_clear), 1);
    m_reset();
    @(negedge CLK);
    disp(5'd9, 4'd1); wbp(0, 5'd20, 4'd5); cycle("rst_hold");
    idle(); nRST = 1'b1; cycle("rst_rel");

    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      idle();
      rs1 = 5'($urandom_range(0, 31));
      rs2 = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) != 0) begin
        logic [4:0] r;
        r = 5'($urandom_range(0, 31));
        if (m_busy[r]) r = 5'd0;
        disp(r, 4'($urandom));
      end else begin
        rd = 5'($urandom_range(0, 31));
      end
      for (int p = 0; p < 4; p++) begin
        if ($urandom_range(0, 1) != 0) begin
          logic [4:0] r;
          r = 5'($urandom_range(0, 31));
          if (m_busy[r] && $urandom_range(0, 3) != 0)
            wbp(p, r, m_own[r]);
          else
            wbp(p, r, 4'($urandom));
        end
      end
      flush = ($urandom_range(0, 39) == 0);
      cycle("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
